// File: rtl/adaptive_filter_ctrl.sv
// rtl/adaptive_filter_ctrl.sv - mode sequencer around adaptive_filter: drain, flush, re-mode, mask warm-up
module adaptive_filter_ctrl #(
  parameter int   DATA_W       = 14,
  parameter int   DRAIN_CYCLES = 1,
  parameter int   WARMUP_LEN   = 6,
  parameter logic RESET_MODE   = 1'b0
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              mode_req_valid,
  input  logic              mode_req,
  output logic              mode_req_ready,
  output logic              mode,
  output logic              busy,
  output logic              switch_done,
  input  logic [DATA_W-1:0] s_tdata,
  input  logic              s_tvalid,
  output logic              s_tready,
  output logic [DATA_W-1:0] flt_s_tdata,
  output logic              flt_s_tvalid,
  output logic              flt_ctrl,
  output logic              flt_srst,
  input  logic [DATA_W-1:0] flt_m_tdata,
  input  logic              flt_m_tvalid,
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tvalid
);

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_FLUSH, ST_WARMUP} state_t;

  // With no warm-up to discard, reset lands directly in RUN.
  localparam state_t     RESET_STATE = (WARMUP_LEN == 0) ? ST_RUN : ST_WARMUP;
  localparam logic [3:0] DRAIN_INIT  = 4'(DRAIN_CYCLES - 1);
  localparam logic [6:0] WARMUP_LAST = 7'(WARMUP_LEN);

  state_t     state, state_next;
  logic       ctrl_q, ctrl_next;
  logic       pend_q, pend_next;
  logic [3:0] drain_cnt, drain_next;
  logic [5:0] warm_cnt, warm_next;
  logic       done_q, done_next;
  logic [6:0] warm_inc;
  logic       req_fire;

  assign s_tready       = ((state == ST_RUN) || (state == ST_WARMUP)) && !srst;
  assign flt_s_tvalid   = s_tvalid & s_tready;
  assign flt_s_tdata    = s_tdata;
  assign flt_srst       = srst || (state == ST_FLUSH);
  assign flt_ctrl       = ctrl_q;
  assign mode           = ctrl_q;
  assign mode_req_ready = (state == ST_RUN) && !srst;
  assign req_fire       = mode_req_valid & mode_req_ready;
  assign busy           = (state != ST_RUN);
  assign switch_done    = done_q;
  assign m_tdata        = flt_m_tdata;
  assign m_tvalid       = flt_m_tvalid && (state != ST_WARMUP) && (state != ST_FLUSH);

  always_comb begin
    state_next = state;
    ctrl_next  = ctrl_q;
    pend_next  = pend_q;
    drain_next = drain_cnt;
    warm_next  = warm_cnt;
    done_next  = 1'b0;
    warm_inc   = {1'b0, warm_cnt} + 7'd1;
    case (state)
      ST_RUN: begin
        if (req_fire) begin
          if (mode_req == ctrl_q) begin
            done_next = 1'b1;
          end else begin
            pend_next  = mode_req;
            drain_next = DRAIN_INIT;
            state_next = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        // The new mode is registered on the way into FLUSH so the filter
        // restarts in it while its history is being cleared.
        if (drain_cnt == 4'd0) begin
          state_next = ST_FLUSH;
          ctrl_next  = pend_q;
        end else begin
          drain_next = drain_cnt - 4'd1;
        end
      end
      ST_FLUSH: begin
        warm_next = 6'd0;
        if (WARMUP_LEN == 0) begin
          state_next = ST_RUN;
          done_next  = 1'b1;
        end else begin
          state_next = ST_WARMUP;
        end
      end
      ST_WARMUP: begin
        if (flt_m_tvalid) begin
          warm_next = warm_inc[5:0];
          if (warm_inc == WARMUP_LAST) begin
            state_next = ST_RUN;
            done_next  = 1'b1;
          end
        end
      end
      default: state_next = RESET_STATE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state     <= RESET_STATE;
      ctrl_q    <= RESET_MODE;
      pend_q    <= RESET_MODE;
      drain_cnt <= 4'd0;
      warm_cnt  <= 6'd0;
      done_q    <= 1'b0;
    end else begin
      state     <= state_next;
      ctrl_q    <= ctrl_next;
      pend_q    <= pend_next;
      drain_cnt <= drain_next;
      warm_cnt  <= warm_next;
      done_q    <= done_next;
    end
  end

endmodule

// File: tb/tb_adaptive_filter_ctrl.sv
// tb/tb_adaptive_filter_ctrl.sv - directed scoreboard bench for adaptive_filter_ctrl
module tb_adaptive_filter_ctrl;

  logic        clk;
  logic        srst;
  logic        mode_req_valid;
  logic        mode_req;
  logic        mode_req_ready;
  logic        mode;
  logic        busy;
  logic        switch_done;
  logic [13:0] s_tdata;
  logic        s_tvalid;
  logic        s_tready;
  logic [13:0] flt_s_tdata;
  logic        flt_s_tvalid;
  logic        flt_ctrl;
  logic        flt_srst;
  logic [13:0] flt_m_tdata;
  logic        flt_m_tvalid;
  logic [13:0] m_tdata;
  logic        m_tvalid;

  adaptive_filter_ctrl dut (
    .clk            (clk),
    .srst           (srst),
    .mode_req_valid (mode_req_valid),
    .mode_req       (mode_req),
    .mode_req_ready (mode_req_ready),
    .mode           (mode),
    .busy           (busy),
    .switch_done    (switch_done),
    .s_tdata        (s_tdata),
    .s_tvalid       (s_tvalid),
    .s_tready       (s_tready),
    .flt_s_tdata    (flt_s_tdata),
    .flt_s_tvalid   (flt_s_tvalid),
    .flt_ctrl       (flt_ctrl),
    .flt_srst       (flt_srst),
    .flt_m_tdata    (flt_m_tdata),
    .flt_m_tvalid   (flt_m_tvalid),
    .m_tdata        (m_tdata),
    .m_tvalid       (m_tvalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in filter: one-cycle latency, history cleared by flt_srst.
  always @(posedge clk) begin
    if (flt_srst) flt_m_tvalid <= 1'b0;
    else          flt_m_tvalid <= flt_s_tvalid;
    flt_m_tdata <= flt_s_tdata;
  end

  int          tests = 0;
  int          fails = 0;
  logic [13:0] exp_q[$];
  int          mask_left = 0;
  int          masked_beats = 0;
  int          sd_count = 0;
  bit          inc_data = 0;
  logic        obs_s_tready, obs_flt_srst, obs_sd, obs_mreq_ready;
  logic        obs_mode, obs_busy, obs_m_tvalid;

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    assert (observed === expected)
      else begin
        fails++;
        $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
  endtask

  task automatic step();
    logic [13:0] e;
    bit          acc;
    @(negedge clk);
    obs_s_tready   = s_tready;
    obs_flt_srst   = flt_srst;
    obs_sd         = switch_done;
    obs_mreq_ready = mode_req_ready;
    obs_mode       = mode;
    obs_busy       = busy;
    obs_m_tvalid   = m_tvalid;
    if (switch_done === 1'b1) sd_count++;
    if (flt_m_tvalid === 1'b1 && m_tvalid === 1'b0) masked_beats++;
    if (m_tvalid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", 32'(m_tdata), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("out_data", 32'(m_tdata), 32'(e));
      end
    end
    acc = (s_tvalid === 1'b1) && (s_tready === 1'b1);
    if (acc) begin
      if (mask_left > 0) mask_left--;
      else exp_q.push_back(s_tdata);
    end
    @(posedge clk);
    #1;
    if (acc && inc_data) s_tdata = s_tdata + 14'd1;
  endtask

  task automatic request(input logic m);
    mode_req_valid = 1'b1;
    mode_req       = m;
    step();
    chk("req_ready", 32'(obs_mreq_ready), 32'd1);
    mode_req_valid = 1'b0;
  endtask

  task automatic drain_flush(input logic m);
    step();
    chk("drain_stall", 32'(obs_s_tready), 32'd0);
    chk("drain_no_srst", 32'(obs_flt_srst), 32'd0);
    chk("drain_mode_old", 32'(obs_mode), 32'(!m));
    chk("drain_fwd", 32'(obs_m_tvalid), 32'd1);
    chk("drain_req_block", 32'(obs_mreq_ready), 32'd0);
    step();
    chk("flush_stall", 32'(obs_s_tready), 32'd0);
    chk("flush_srst", 32'(obs_flt_srst), 32'd1);
    chk("flush_mode_new", 32'(obs_mode), 32'(m));
    chk("flush_req_block", 32'(obs_mreq_ready), 32'd0);
    mask_left    = 6;
    masked_beats = 0;
  endtask

  task automatic wait_done(input string tag);
    bit seen;
    seen     = 0;
    sd_count = 0;
    for (int n = 0; n < 40 && !seen; n++) begin
      step();
      if (obs_sd === 1'b1) seen = 1;
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    chk({tag, "_masked_beats"}, 32'(masked_beats), 32'd6);
    chk({tag, "_busy_low"}, 32'(obs_busy), 32'd0);
    chk({tag, "_first_fwd"}, 32'(obs_m_tvalid), 32'd1);
    step();
    step();
    chk({tag, "_single_pulse"}, 32'(sd_count), 32'd1);
  endtask

  initial begin
    int done_k;
    srst = 1'b1; mode_req_valid = 1'b0; mode_req = 1'b0;
    s_tvalid = 1'b0; s_tdata = 14'h0040;

    // reset then warm-up with constant data
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_flt_srst", 32'(obs_flt_srst), 32'd1);
      chk("rst_s_tready", 32'(obs_s_tready), 32'd0);
      chk("rst_req_ready", 32'(obs_mreq_ready), 32'd0);
      chk("rst_mode", 32'(obs_mode), 32'd0);
      chk("rst_busy", 32'(obs_busy), 32'd1);
      chk("rst_done", 32'(obs_sd), 32'd0);
      chk("rst_m_tvalid", 32'(obs_m_tvalid), 32'd0);
    end
    srst = 1'b0; s_tvalid = 1'b1;
    mask_left = 6; masked_beats = 0;
    wait_done("warmup");
    inc_data = 1;

    // same-mode request
    mode_req_valid = 1'b1; mode_req = 1'b0;
    step();
    chk("same_req_ready", 32'(obs_mreq_ready), 32'd1);
    chk("same_tready_T", 32'(obs_s_tready), 32'd1);
    mode_req_valid = 1'b0;
    step();
    chk("same_done_T1", 32'(obs_sd), 32'd1);
    chk("same_tready_T1", 32'(obs_s_tready), 32'd1);
    chk("same_no_srst", 32'(obs_flt_srst), 32'd0);
    chk("same_busy", 32'(obs_busy), 32'd0);
    step();
    chk("same_done_T2", 32'(obs_sd), 32'd0);
    chk("same_tready_T2", 32'(obs_s_tready), 32'd1);

    // switch 0->1 with continuous input
    request(1'b1);
    drain_flush(1'b1);
    step();
    chk("sw01_tready_back", 32'(obs_s_tready), 32'd1);
    chk("sw01_srst_off", 32'(obs_flt_srst), 32'd0);
    chk("sw01_mode", 32'(obs_mode), 32'd1);
    wait_done("sw01");

    // switch 1->0 with sparse warm-up input
    request(1'b0);
    drain_flush(1'b0);
    done_k = -1;
    sd_count = 0;
    for (int k = 0; k < 60; k++) begin
      s_tvalid = ((k % 4) == 0);
      step();
      if (obs_sd === 1'b1) begin
        done_k = k;
        break;
      end
    end
    chk("sparse_done_cycle", 32'(done_k), 32'd22);
    chk("sparse_masked", 32'(masked_beats), 32'd6);
    s_tvalid = 1'b1;
    step();
    step();

    // reset in the middle of an integrator warm-up
    request(1'b1);
    drain_flush(1'b1);
    for (int n = 0; n < 20 && masked_beats < 3; n++) step();
    chk("mid_masked3", 32'(masked_beats), 32'd3);
    srst = 1'b1; s_tvalid = 1'b0;
    step();
    chk("mid_rst_srst", 32'(obs_flt_srst), 32'd1);
    chk("mid_rst_tready", 32'(obs_s_tready), 32'd0);
    step();
    chk("mid_rst_mode", 32'(obs_mode), 32'd0);
    chk("mid_rst_busy", 32'(obs_busy), 32'd1);
    srst = 1'b0; s_tvalid = 1'b1;
    mask_left = 6; masked_beats = 0;
    wait_done("mid_rst");
    chk("mid_rst_mode_after", 32'(obs_mode), 32'd0);

    // request held from DRAIN until the first RUN cycle
    request(1'b1);
    mode_req_valid = 1'b1; mode_req = 1'b0;
    drain_flush(1'b1);
    done_k = -1;
    for (int n = 0; n < 40; n++) begin
      step();
      if (obs_sd === 1'b1) begin
        done_k = n;
        chk("held_accept", 32'(obs_mreq_ready), 32'd1);
        break;
      end
      chk("held_blocked", 32'(obs_mreq_ready), 32'd0);
    end
    chk("held_done_cycle", 32'(done_k), 32'd7);
    chk("held_masked", 32'(masked_beats), 32'd6);
    mode_req_valid = 1'b0;
    drain_flush(1'b0);
    wait_done("held");
    chk("held_mode_final", 32'(obs_mode), 32'd0);

    s_tvalid = 1'b0;
    step(); step(); step();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/adaptive_filter_ctrl.md
# adaptive_filter_ctrl

Mode sequencer placed in front of and behind `adaptive_filter`. It owns the filter's `ctrl` and reset inputs, and accepts integrator/differentiator mode-change requests from the register or control side. On a change it stalls the upstream stream, drains the filter, resets the filter history, and applies the new mode. It then suppresses the warm-up outputs so that downstream only sees samples computed entirely in one mode.

## Interface
- `DATA_W`, 14: sample width, signed Q7.6.
- `DRAIN_CYCLES`, 1: filter input-to-output latency that must elapse after the last accepted sample; range 1..15.
- `WARMUP_LEN`, 6: number of filter output beats discarded after each filter reset (equals the filter's delay-line depth); range 0..63.
- `RESET_MODE`, 0: mode applied by `srst`; 0 = differentiator, 1 = integrator.

Ports:
- `clk`  in  1  clock.
- `srst`  in  1  reset; synchronous, active-high.
- `mode_req_valid`  in  1  mode-change request valid.
- `mode_req`  in  1  requested mode (1 = integrator).
- `mode_req_ready`  out  1  request accepted when both valid and ready are high.
- `mode`  out  1  currently applied mode, equal to `flt_ctrl`.
- `busy`  out  1  high in every state except RUN.
- `switch_done`  out  1  one-cycle pulse when a request completes or the post-reset warm-up ends.
- `s_tdata`  in  DATA_W  upstream sample.
- `s_tvalid`  in  1  upstream valid.
- `s_tready`  out  1  upstream ready; a transfer occurs when `s_tvalid & s_tready`.
- `flt_s_tdata`  out  DATA_W  to the filter `s_tdata`.
- `flt_s_tvalid`  out  1  to the filter `s_tvalid`.
- `flt_ctrl`  out  1  to the filter `ctrl`.
- `flt_srst`  out  1  to the filter `srst`.
- `flt_m_tdata`  in  DATA_W  from the filter `m_tdata`.
- `flt_m_tvalid`  in  1  from the filter `m_tvalid`.
- `m_tdata`  out  DATA_W  downstream sample.
- `m_tvalid`  out  1  downstream valid. There is no downstream backpressure.

## Operation
- FSM states: RUN, DRAIN, FLUSH, WARMUP. The state is registered.
- Combinational outputs:
  - `s_tready` = (RUN or WARMUP) and not `srst`.
  - `flt_s_tvalid` = `s_tvalid & s_tready`.
  - `flt_s_tdata` = `s_tdata`.
  - `flt_srst` = `srst` or (state == FLUSH).
  - `mode_req_ready` = (state == RUN) and not `srst`.
  - `m_tdata` = `flt_m_tdata`.
  - `m_tvalid` = `flt_m_tvalid` and (state != WARMUP) and (state != FLUSH).
- RUN:
  - A request whose `mode_req` equals `mode` is accepted. The state does not change and `switch_done` pulses on the next cycle.
  - A request whose `mode_req` differs from `mode` is accepted. The new mode is latched into `pend_mode`, the drain counter is loaded with DRAIN_CYCLES−1, and the next state is DRAIN.
  - A sample transferred in the same cycle as the request is valid and reaches the filter.
- DRAIN:
  - No input transfers.
  - Filter outputs are still forwarded.
  - The drain counter decrements each cycle; at 0 the next state is FLUSH.
- FLUSH:
  - Lasts exactly one cycle.
  - `flt_srst` = 1.
  - `flt_ctrl` <= `pend_mode` is registered on entry, so the filter sees the new mode from this cycle.
  - The warm-up counter is cleared.
  - Next state is WARMUP, or RUN when WARMUP_LEN = 0; in that case `switch_done` pulses on the next cycle.
- WARMUP:
  - Input transfers are allowed.
  - Each `flt_m_tvalid` beat increments the warm-up counter and is not forwarded.
  - On the beat that makes the count equal WARMUP_LEN, the next state is RUN and `switch_done` pulses on the next cycle.
  - Idle gaps do not advance the count.
- `mode_req_valid` asserted outside RUN is held off; the requester keeps it asserted until it is accepted.
- Reset (`srst` at any time, including mid-switch):
  - state = WARMUP, `flt_ctrl` = RESET_MODE, `pend_mode` = RESET_MODE, counters = 0, `switch_done` = 0.
  - Any pending request is dropped.
  - The filter is reset through `flt_srst`.
  - With WARMUP_LEN = 0, reset goes to RUN instead.

## Timing
- Reset values: `mode` = RESET_MODE, `busy` = 1 (0 if WARMUP_LEN = 0), `switch_done` = 0, `s_tready` = 0, `flt_srst` = 1, `mode_req_ready` = 0, `m_tvalid` = 0.
- Switch sequence, with the request accepted at cycle T:
  - DRAIN occupies T+1 .. T+DRAIN_CYCLES.
  - FLUSH is at T+DRAIN_CYCLES+1; `flt_ctrl` changes here.
  - WARMUP starts at T+DRAIN_CYCLES+2, when `s_tready` returns to 1.
- The upstream stall is DRAIN_CYCLES+1 cycles.
- The filter output for a sample accepted at T appears at T+1 and is forwarded, because DRAIN_CYCLES ≥ 1.
- `switch_done` pulses exactly one cycle after the last suppressed beat.

## Test plan
- Reset then warm-up:
  - Stimulus: hold `srst` for 3 cycles, then drive `s_tvalid` = 1 continuously with `s_tdata` = 0x0040.
  - Required: `flt_srst` = 1 and `s_tready` = 0 during reset.
  - Required: the first 6 `flt_m_tvalid` beats are masked, `switch_done` pulses once, `busy` falls, and the 7th beat is forwarded.
- Switch 0→1 with continuous input:
  - Stimulus: request accepted at T.
  - Required: `s_tready` = 0 at T+1..T+2.
  - Required: `flt_srst` = 1 only at T+2, and `flt_ctrl` = 1 from T+2.
  - Required: the output for T's sample is forwarded at T+1; 6 beats are masked; `switch_done` pulses afterwards.
- Same-mode request:
  - Stimulus: `mode_req` = 0 while `mode` = 0.
  - Required: `s_tready` never drops, `flt_srst` stays 0, and `switch_done` pulses at T+1.
- Sparse warm-up:
  - Stimulus: during WARMUP, `s_tvalid` toggles 1,0,0,0.
  - Required: warm-up completes only after 6 valid output beats, and idle cycles do not count.
- Reset mid-warm-up:
  - Stimulus: assert `srst` after 3 masked beats in integrator mode.
  - Required: `flt_ctrl` returns to 0, the count restarts, and a full 6 beats are masked again.
- Held request:
  - Stimulus: assert `mode_req_valid` = 1 during DRAIN and keep it asserted.
  - Required: `mode_req_ready` stays 0 until the first RUN cycle, and it is accepted exactly there.
